mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one SRAM-like memory port between the IF-stage fetch requester and the MEM-stage load/store requester.
- One outstanding transaction at a time.
- Data requests have priority, with a bounded streak so fetch cannot starve.
- Exports busy/stall indications to the hazard unit and discards fetch responses killed by a pipeline flush.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_DATA_STREAK, 2, consecutive data grants allowed while inst_req is pending.
- TIMEOUT_CYCLES, 255, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled at posedge clk).
- inst_req  in  1  fetch request.
- inst_addr  in  ADDR_W  fetch address.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch data valid.
- inst_rdata  out  DATA_W  fetch data.
- data_req  in  1  load/store request.
- data_wr  in  1  1 = store.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_addr_ok  out  1  load/store request accepted.
- data_data_ok  out  1  load data valid / store complete.
- data_rdata  out  DATA_W  load data.
- flush  in  1  pipeline flush (exception/branch); kills outstanding fetch.
- bus_req  out  1  memory request.
- bus_wr  out  1  write.
- bus_size  out  2  size.
- bus_addr  out  ADDR_W  address.
- bus_wdata  out  DATA_W  write data.
- bus_addr_ok  in  1  memory accepted request.
- bus_data_ok  in  1  memory response.
- bus_rdata  in  DATA_W  read data.
- busy  out  1  FSM not IDLE.
- owner_data  out  1  current/last grant was data.
- bus_err  out  1  timeout abort pulse.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE; all outputs 0; streak counter=0; drop flag=0.
- State machine:
  - IDLE:
    - Arbitration:
      - If data_req and (inst_req=0 or streak<MAX_DATA_STREAK): grant data.
      - Else if inst_req and flush=0: grant inst.
      - Else stay IDLE.
    - Grant: requester's addr_ok=1 combinationally in the same cycle. Latch wr/size/addr/wdata (inst: wr=0, size=2) and owner. Next state is ADDR.
    - Streak counter:
      - Data grant while inst_req=1: streak+1.
      - Inst grant, or no inst_req: streak=0.
  - ADDR:
    - bus_req=1 with latched fields, held stable until bus_addr_ok.
    - bus_addr_ok=1 moves to WAIT.
  - WAIT:
    - bus_req=0.
    - On bus_data_ok: owner's data_ok=1 and rdata=bus_rdata, combinational and for that cycle only. Next state is IDLE.
- Latency: request to bus_req is 1 cycle. bus_data_ok to data_ok is 0 cycles. Minimum 3 cycles per transaction.
- bus_addr_ok and bus_data_ok in the same cycle while in ADDR: ADDR→WAIT only; the response is taken in WAIT. The memory side guarantees data_ok no earlier than the cycle after addr_ok.
- Flush:
  - flush=1 while owner=inst in ADDR/WAIT sets drop.
  - With drop set, inst_data_ok stays 0 for that transaction; the bus transaction still completes.
  - drop clears on return to IDLE.
  - Flush never affects data transactions.
- flush in IDLE with only inst_req: no grant.
- A requester whose addr_ok is not asserted holds its req and fields unchanged.
- Unselected addr_ok/data_ok are always 0. The two data_ok outputs are never both 1.
- busy=1 in ADDR and WAIT. owner_data holds the latched owner.
- Reset mid-transaction returns to IDLE immediately. Any later bus_data_ok is ignored.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - Cycle counter runs in ADDR/WAIT and clears on IDLE.
  - When it reaches TIMEOUT_CYCLES: force IDLE, pulse bus_err for 1 cycle, and pulse the owner's data_ok with rdata=0 (suppressed if drop is set).
  - Counter width is ceil(log2(TIMEOUT_CYCLES+1)).
- Undefined: no counter; the FSM waits indefinitely; bus_err is tied 0.

Test Plan:
- Reset then lone fetch:
  - rst=0 for 2 cycles, then inst_req with addr 0xBFC00000.
  - Expect: inst_addr_ok same cycle; bus_req next cycle with bus_addr=0xBFC00000, bus_wr=0.
  - Memory returns 0x24080001 one cycle after addr_ok. Expect inst_data_ok with rdata=0x24080001 that cycle.
- Simultaneous requests:
  - inst_req and a data store (addr 0x80000010, wdata 0xDEADBEEF, size 2) in the same cycle.
  - Expect: data granted first, bus_wr=1 with fields matching; inst granted in the IDLE cycle after data_data_ok.
- Starvation bound with MAX_DATA_STREAK=2: data_req and inst_req held continuously. Expect grant order data, data, inst, data, data, inst.
- Flush kill:
  - Fetch in WAIT, flush pulsed.
  - Expect: no inst_data_ok when bus_data_ok arrives; busy drops next cycle; a following data load completes normally.
- Bus stall: bus_addr_ok held low 10 cycles. Expect bus_req, bus_addr and bus_wdata stable for all 10 cycles and busy=1 throughout.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): bus never responds to a load. Expect bus_err pulse and data_data_ok with rdata=0 after 8 cycles, then IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of every handshake signal around mem_port_arbiter.
//   Fetch side : inst_req/inst_addr in, inst_addr_ok/inst_data_ok/inst_rdata out
//   Data side  : data_req/data_wr/data_size/data_addr/data_wdata in,
//                data_addr_ok/data_data_ok/data_rdata out
//   Control    : flush in
//   Memory side: bus_req/bus_wr/bus_size/bus_addr/bus_wdata out,
//                bus_addr_ok/bus_data_ok/bus_rdata in
//   Status     : busy, owner_data, bus_err out
// Modports: slave = the arbiter itself, master = the requesters plus memory around it.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              flush;

  logic              bus_req;
  logic              bus_wr;
  logic [1:0]        bus_size;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  logic              busy;
  logic              owner_data;
  logic              bus_err;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    input  flush,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata,
    output busy, owner_data, bus_err
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    output flush,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata,
    input  busy, owner_data, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like memory port between instruction fetch and
// load/store. One transaction in flight; data wins arbitration unless it has already
// taken MAX_DATA_STREAK grants in a row while a fetch waited. A flush during an
// outstanding fetch lets the bus transaction finish but hides its response.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   port - mem_port_arbiter_if.slave: fetch/data requester handshakes, flush,
//          memory bus handshake, and busy/owner_data/bus_err status.
//
// Optional build macro MEM_ARB_TIMEOUT_EN: adds a watchdog that aborts a transaction
// after TIMEOUT_CYCLES cycles in ADDR/WAIT, pulsing bus_err and a zero-data response.
// Without it bus_err is tied 0 and the FSM waits indefinitely.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_DATA_STREAK = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave port
);

  localparam int unsigned StreakW = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;

  typedef enum logic [1:0] {StIdle, StAddr, StWait} state_e;

  state_e              state_q, state_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic                owner_data_q, owner_data_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                drop_q, drop_d;

  logic grant_data;
  logic grant_inst;
  logic resp;
  logic inst_kill;
  logic timeout;

  // A response only counts while out of reset and actually waiting for one, so a
  // stale bus_data_ok after a mid-transaction reset is ignored.
  assign resp      = rst && (state_q == StWait) && port.bus_data_ok;
  // Flush in the response cycle itself also kills the fetch.
  assign inst_kill = drop_q || port.flush;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_q == StIdle || state_d == StIdle) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A genuine response in the same cycle takes precedence over the abort.
  assign timeout = rst && (state_q != StIdle) && (cnt_q == CntW'(TIMEOUT_CYCLES)) && !resp;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration and next state.
  always_comb begin
    grant_data = 1'b0;
    grant_inst = 1'b0;
    if (rst && state_q == StIdle) begin
      if (port.data_req && (!port.inst_req || streak_q < StreakW'(MAX_DATA_STREAK))) begin
        grant_data = 1'b1;
      end else if (port.inst_req && !port.flush) begin
        grant_inst = 1'b1;
      end
    end

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_data || grant_inst) state_d = StAddr;
      // Same-cycle data_ok here is not a response; it is taken in WAIT.
      StAddr:  if (port.bus_addr_ok) state_d = StWait;
      StWait:  if (port.bus_data_ok) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (timeout) begin
      state_d = StIdle;
    end
  end

  // Outputs.
  always_comb begin
    port.inst_addr_ok = grant_inst;
    port.data_addr_ok = grant_data;
    port.bus_req      = rst && (state_q == StAddr) && !timeout;
    port.bus_wr       = wr_q;
    port.bus_size     = size_q;
    port.bus_addr     = addr_q;
    port.bus_wdata    = wdata_q;
    port.inst_data_ok = 1'b0;
    port.inst_rdata   = '0;
    port.data_data_ok = 1'b0;
    port.data_rdata   = '0;
    if (resp || timeout) begin
      if (owner_data_q) begin
        port.data_data_ok = 1'b1;
        port.data_rdata   = resp ? port.bus_rdata : '0;
      end else if (!inst_kill) begin
        port.inst_data_ok = 1'b1;
        port.inst_rdata   = resp ? port.bus_rdata : '0;
      end
    end
    port.busy       = (state_q != StIdle);
    port.owner_data = owner_data_q;
    port.bus_err    = timeout;
  end

  // Request latch, streak and drop next state.
  always_comb begin
    owner_data_d = owner_data_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    streak_d     = streak_q;

    if (grant_data) begin
      owner_data_d = 1'b1;
      wr_d         = port.data_wr;
      size_d       = port.data_size;
      addr_d       = port.data_addr;
      wdata_d      = port.data_wdata;
    end else if (grant_inst) begin
      owner_data_d = 1'b0;
      wr_d         = 1'b0;
      size_d       = 2'd2;
      addr_d       = port.inst_addr;
      wdata_d      = '0;
    end

    // Count data grants only while a fetch is being held off.
    if (grant_data && port.inst_req) begin
      streak_d = streak_q + 1'b1;
    end else if (grant_inst || !port.inst_req) begin
      streak_d = '0;
    end

    drop_d = drop_q;
    if (state_q != StIdle && !owner_data_q && port.flush) begin
      drop_d = 1'b1;
    end
    if (state_d == StIdle) begin
      drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_data_q <= 1'b0;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      streak_q     <= '0;
      drop_q       <= 1'b0;
    end else begin
      owner_data_q <= owner_data_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      streak_q     <= streak_d;
      drop_q       <= drop_d;
    end
  end

endmodule
